dmem_responder: RTL and testbench

- Memory-side responder for the core's data-memory request/response interface. The core's load/store path is the initiator.
- Accepts one request at a time through a valid/ready handshake and serves it from an internal word-addressed array.
- Supports byte-enable writes and full-word reads, with a configurable number of wait states.
- Returns an error response for misaligned or out-of-range addresses, so loads and stores can be exercised against a multi-cycle memory model.

---
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 tb/tb_dmem_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's data-memory port.
// It accepts one load or store at a time over a valid/ready handshake and
// serves it from an internal word array after WAIT_CYCLES wait states.
// Misaligned or out-of-range byte addresses get an error response and
// never touch the array.
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);
    localparam int         DEPTH  = 2 ** ADDR_W;

    state_t      state;
    logic [3:0]  cnt;

    // Request fields captured at acceptance; they are data, so never reset.
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    logic [31:0] mem [0:DEPTH-1];

    // Operands of the access that happens on this edge, if any.
    logic              req_hs;
    logic              last_wait;
    logic              commit;
    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_be;
    logic              acc_err;
    logic [ADDR_W-1:0] acc_idx;

    // Misaligned, or any address bit above the array's byte range set.
    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
    endfunction

    // Select access operands: with zero wait states the access happens on the
    // acceptance edge itself, so the live request fields are used directly.
    always_comb begin
        req_hs    = req_valid & req_ready;
        last_wait = (cnt <= 4'd1);
        if (state == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_we    = lat_we;
            acc_addr  = lat_addr;
            acc_wdata = lat_wdata;
            acc_be    = lat_be;
        end
        acc_err = addr_err(acc_addr);
        acc_idx = acc_addr[ADDR_W+1:2];
        // rst is checked here as well so a reset held across an edge can
        // never let a store slip into the array.
        commit  = !rst &&
                  (((state == WAIT) && last_wait) ||
                   ((state == IDLE) && req_hs && (WAIT_CYCLES == 0)));
    end

    // Capture the request on the acceptance handshake.
    always_ff @(posedge clk) begin
        if (req_hs) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
        end
    end

    // Byte-enabled store into the array on the commit edge of a legal store.
    always_ff @(posedge clk) begin
        if (commit && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with registered handshake outputs and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            cnt       <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_hs) begin
                        cnt       <= WAIT_N;
                        req_ready <= 1'b0;
                        if (WAIT_N == 4'd0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= acc_err;
                            rsp_rdata <= (acc_err || acc_we) ? 32'd0 : mem[acc_idx];
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (last_wait) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || acc_we) ? 32'd0 : mem[acc_idx];
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    // The wait counter is four bits wide; larger settings cannot be honoured.
    always_ff @(posedge clk) begin
        assert (WAIT_CYCLES >= 0 && WAIT_CYCLES <= 15)
            else $error("dmem_responder: WAIT_CYCLES=%0d outside 0..15", WAIT_CYCLES);
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 wait states and 0 wait states)
// driven by directed and random loads/stores. Expected responses come from a
// plain word-array model and are queued at issue time; a monitor per instance
// pops and compares on every response handshake.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_we = '0;
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic [31:0] rsp_rdata [2];
    logic [1:0]  rsp_err;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected response: {err, rdata}
    logic [32:0] exp_q [2][$];
    logic [31:0] mdl   [2][1024];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_responder #(
            .ADDR_W(10),
            .WAIT_CYCLES(g == 0 ? 2 : 0)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_we   (req_we[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .req_be   (req_be[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g])
        );

        // Response monitor: a handshake is seen at the falling edge before
        // the rising edge that completes it.
        always @(negedge clk) begin
            if (!rst && rsp_valid[g] && rsp_ready[g]) begin
                n_chk++;
                if (exp_q[g].size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected[%0d]: got err=%0b rdata=%h, required no response",
                             g, rsp_err[g], rsp_rdata[g]);
                end else begin
                    logic [32:0] e;
                    e = exp_q[g].pop_front();
                    if ({rsp_err[g], rsp_rdata[g]} !== e) begin
                        n_fail++;
                        $display("FAIL rsp_data[%0d]: got err=%0b rdata=%h, required err=%0b rdata=%h",
                                 g, rsp_err[g], rsp_rdata[g], e[32], e[31:0]);
                    end
                end
            end
        end
    end

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Model of one access: returns {err, rdata} and updates the model array.
    function automatic logic [32:0] model(input int d, input logic we, input logic [31:0] addr,
                                          input logic [31:0] wdata, input logic [3:0] be);
        logic        err;
        int          w;
        logic [31:0] word;
        err = (addr % 4 != 0) || (addr >= 32'd4096);
        if (err) return {1'b1, 32'd0};
        w = int'(addr / 4);
        if (!we) return {1'b0, mdl[d][w]};
        word = mdl[d][w];
        for (int i = 0; i < 4; i++)
            if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
        mdl[d][w] = word;
        return {1'b0, 32'd0};
    endfunction

    // One full transaction: handshake, latency check, optional back-pressure
    // with a rejected competing request, then response handshake.
    task automatic xact(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int stall);
        logic [32:0] e;
        bit          ok;
        int          lat;
        @(posedge clk); #1;
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
        req_wdata[d] = wdata; req_be[d] = be; rsp_ready[d] = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[d]) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL req_timeout[%0d]: req_ready stayed 0, required 1", d);
            req_valid[d] = 1'b0;
            return;
        end
        e = model(d, we, addr, wdata, be);
        exp_q[d].push_back(e);
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom; req_wdata[d] = $urandom; req_we[d] = 1'($urandom);
        // Edges after the acceptance edge until rsp_valid is up.
        lat = 0;
        ok  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid[d]) begin ok = 1; break; end
            lat++;
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL rsp_timeout[%0d]: rsp_valid stayed 0, required 1", d);
            void'(exp_q[d].pop_back());
            return;
        end
        chk($sformatf("latency[%0d]", d), 32'(lat), 32'(wait_of(d)));
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            req_valid[d] = 1'b1; req_we[d] = 1'b1; req_addr[d] = 32'h40; req_be[d] = 4'hF;
            @(negedge clk);
            chk($sformatf("stall_valid[%0d]", d), 32'(rsp_valid[d]), 32'd1);
            chk($sformatf("stall_rdata[%0d]", d), rsp_rdata[d], e[31:0]);
            chk($sformatf("stall_err[%0d]", d), 32'(rsp_err[d]), 32'(e[32]));
            chk($sformatf("stall_req_ready[%0d]", d), 32'(req_ready[d]), 32'd0);
        end
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        @(negedge clk);
        chk($sformatf("post_req_ready[%0d]", d), 32'(req_ready[d]), 32'd1);
        chk($sformatf("post_rsp_valid[%0d]", d), 32'(rsp_valid[d]), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_req_ready[%0d]", tag, d), 32'(req_ready[d]), 32'd1);
            chk($sformatf("%s_rsp_valid[%0d]", tag, d), 32'(rsp_valid[d]), 32'd0);
            chk($sformatf("%s_rsp_rdata[%0d]", tag, d), rsp_rdata[d], 32'd0);
            chk($sformatf("%s_rsp_err[%0d]", tag, d), 32'(rsp_err[d]), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_addr[d] = '0; req_wdata[d] = '0; req_be[d] = '0;
            for (int w = 0; w < 1024; w++) mdl[d][w] = '0;
        end
        // Reset, then idle with no requests.
        repeat (3) begin
            @(negedge clk);
            chk_idle("in_reset");
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_idle("after_reset");
        end

        // Store then load, full word.
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
        // Partial store of byte 0.
        xact(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 0);
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
        // Error cases around a known word at 0x0.
        xact(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0);
        xact(0, 1'b0, 32'h13, 32'h0, 4'h0, 0);
        xact(0, 1'b1, 32'h1000, 32'h11111111, 4'hF, 0);
        xact(0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
        // Store with no byte enables still responds and changes nothing.
        xact(0, 1'b1, 32'h0, 32'hFFFFFFFF, 4'h0, 0);
        xact(0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
        // Back-pressure for 5 cycles with a competing request.
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 5);

        // Reset during WAIT drops the store.
        xact(0, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, 0);
        @(posedge clk); #1;
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20;
        req_wdata[0] = 32'h12345678; req_be[0] = 4'hF;
        @(negedge clk);
        chk("rst_mid_accept", 32'(req_ready[0]), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_req_ready", 32'(req_ready[0]), 32'd1);
        chk("rst_mid_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        xact(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);

        // Zero wait states: store then load.
        xact(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        xact(1, 1'b0, 32'h10, 32'h0, 4'h0, 0);
        xact(1, 1'b0, 32'h11, 32'h0, 4'h0, 2);

        // Random traffic on both instances over 16 preloaded words.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++)
                xact(d, 1'b1, 32'(w * 4), $urandom, 4'hF, 0);
            for (int n = 0; n < 40; n++) begin
                logic [31:0] a;
                int          kind;
                kind = $urandom_range(0, 9);
                a = 32'($urandom_range(0, 15) * 4);
                if (kind == 0) a = a + 32'($urandom_range(1, 3));
                else if (kind == 1) a = a | (32'h1000 << $urandom_range(0, 19));
                xact(d, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
            end
        end

        repeat (3) @(negedge clk);
        chk("leftover_q0", 32'(exp_q[0].size()), 32'd0);
        chk("leftover_q1", 32'(exp_q[1].size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
